// File: rtl/microwave_btn_event.sv
// Front-panel button event generator: slow sampling tick plus per-button
// press / release / long-press / auto-repeat pulses from debounced levels.
module microwave_btn_event #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 25_000_000,
    parameter int LONG_TICKS   = 8,
    parameter int REPEAT_TICKS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_db,
    output logic             tick_4hz,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] btn_long
);

    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(MAXT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        LONG  = 2'd2
    } state_t;

    logic [TW-1:0]    tick_cnt_reg;
    logic             tick_reg;
    logic [N_BTN-1:0] btn_prev_reg;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_reg <= '0;
            tick_reg     <= 1'b0;
            btn_prev_reg <= '0;
        end else begin
            tick_reg     <= (tick_cnt_reg == TW'(TICK_DIV - 1));
            if (tick_cnt_reg == TW'(TICK_DIV - 1))
                tick_cnt_reg <= '0;
            else
                tick_cnt_reg <= tick_cnt_reg + TW'(1);
            btn_prev_reg <= btn_db;
        end
    end

    assign tick_4hz = tick_reg;
    assign rise     = btn_db & ~btn_prev_reg;
    assign fall     = ~btn_db & btn_prev_reg;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            state_t        state_reg, state_next;
            logic [HW-1:0] hold_reg, hold_next;
            logic          press_reg, press_next;
            logic          rel_reg, rel_next;
            logic          lng_reg, lng_next;
            logic          rpt_reg, rpt_next;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= IDLE;
                    hold_reg  <= '0;
                    press_reg <= 1'b0;
                    rel_reg   <= 1'b0;
                    lng_reg   <= 1'b0;
                    rpt_reg   <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    hold_reg  <= hold_next;
                    press_reg <= press_next;
                    rel_reg   <= rel_next;
                    lng_reg   <= lng_next;
                    rpt_reg   <= rpt_next;
                end
            end

            // A fall always beats a coincident tick, so a release never
            // carries a long or repeat event with it.
            always_comb begin
                state_next = state_reg;
                hold_next  = hold_reg;
                press_next = 1'b0;
                rel_next   = 1'b0;
                lng_next   = 1'b0;
                rpt_next   = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (rise[gi]) begin
                            state_next = PRESS;
                            press_next = 1'b1;
                            hold_next  = '0;
                        end
                    end
                    PRESS: begin
                        if (fall[gi]) begin
                            state_next = IDLE;
                            rel_next   = 1'b1;
                        end else if (tick_reg) begin
                            if (hold_reg == HW'(LONG_TICKS - 1)) begin
                                state_next = LONG;
                                lng_next   = 1'b1;
                                hold_next  = '0;
                            end else begin
                                hold_next = hold_reg + HW'(1);
                            end
                        end
                    end
                    LONG: begin
                        if (fall[gi]) begin
                            state_next = IDLE;
                            rel_next   = 1'b1;
                        end else if (tick_reg) begin
                            if (hold_reg == HW'(REPEAT_TICKS - 1)) begin
                                rpt_next  = 1'b1;
                                hold_next = '0;
                            end else begin
                                hold_next = hold_reg + HW'(1);
                            end
                        end
                    end
                    default: begin
                        state_next = IDLE;
                        hold_next  = '0;
                    end
                endcase
            end

            assign press_pulse[gi]   = press_reg;
            assign release_pulse[gi] = rel_reg;
            assign long_pulse[gi]    = lng_reg;
            assign repeat_pulse[gi]  = rpt_reg;
            assign btn_long[gi]      = (state_reg == LONG);
        end
    endgenerate

endmodule

// File: tb/tb_microwave_btn_event.sv
// Bench for microwave_btn_event: directed scenarios then random button
// activity, every cycle compared against a tick-counting reference model.
module tb_microwave_btn_event;

    localparam int NB = 2;
    localparam int TD = 4;
    localparam int LT = 3;
    localparam int RT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn_db = '0;
    logic          tick_4hz;
    logic [NB-1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, btn_long;

    microwave_btn_event #(
        .N_BTN(NB), .TICK_DIV(TD), .LONG_TICKS(LT), .REPEAT_TICKS(RT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_db       (btn_db),
        .tick_4hz     (tick_4hz),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .btn_long     (btn_long)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: edges since reset, previous level, and ticks held per button.
    int            since = 0;
    logic [NB-1:0] prev_m = '0;
    bit            held [NB];
    int            ticks [NB];
    logic          e_tick;
    logic [NB-1:0] e_press, e_rel, e_long, e_rpt, e_blong;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %b expected %b (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit tick_due();
        return (since > 0) && (since % TD == 0);
    endfunction

    task automatic step(input logic [NB-1:0] b, input logic r);
        bit tick_now;
        btn_db = b;
        reset  = r;
        @(posedge clk);
        #1;
        tick_now = tick_due();
        e_press = '0; e_rel = '0; e_long = '0; e_rpt = '0;
        if (r) begin
            since  = 0;
            prev_m = '0;
            for (int i = 0; i < NB; i++) begin held[i] = 0; ticks[i] = 0; end
        end else begin
            since++;
            for (int i = 0; i < NB; i++) begin
                if (held[i]) begin
                    if (!b[i] && prev_m[i]) begin
                        e_rel[i] = 1'b1;
                        held[i]  = 0;
                    end else if (tick_now) begin
                        ticks[i]++;
                        if (ticks[i] == LT)
                            e_long[i] = 1'b1;
                        else if (ticks[i] > LT && (ticks[i] - LT) % RT == 0)
                            e_rpt[i] = 1'b1;
                    end
                end else if (b[i] && !prev_m[i]) begin
                    e_press[i] = 1'b1;
                    held[i]    = 1;
                    ticks[i]   = 0;
                end
            end
            prev_m = b;
        end
        e_tick = !r && tick_due();
        for (int i = 0; i < NB; i++) e_blong[i] = held[i] && ticks[i] >= LT;
        chk("tick_4hz", {{(NB-1){1'b0}}, tick_4hz}, {{(NB-1){1'b0}}, e_tick});
        chk("press_pulse", press_pulse, e_press);
        chk("release_pulse", release_pulse, e_rel);
        chk("long_pulse", long_pulse, e_long);
        chk("repeat_pulse", repeat_pulse, e_rpt);
        chk("btn_long", btn_long, e_blong);
    endtask

    task automatic timeout(input string tag);
        total_cnt++;
        $error("FAIL %s: wait bound expired, got timeout expected event", tag);
    endtask

    initial begin
        int guard;
        logic [NB-1:0] rb;
        logic          rr;

        // Reset state and tick cadence
        repeat (3) step(2'b00, 1'b1);
        repeat (13) step(2'b00, 1'b0);

        // Short press on button 0
        repeat (5) step(2'b01, 1'b0);
        repeat (3) step(2'b00, 1'b0);

        // Long press with auto-repeat on button 1
        repeat (30) step(2'b10, 1'b0);
        repeat (2) step(2'b00, 1'b0);

        // Fall coincident with the tick that would complete the long hold
        guard = 0;
        while (!(held[1] && ticks[1] == LT - 1 && tick_due()) && guard < 100) begin
            step(2'b10, 1'b0);
            guard++;
        end
        if (guard >= 100) timeout("collide_fall_align");
        step(2'b00, 1'b0);
        chk("collide_fall_release", release_pulse, 2'b10);
        chk("collide_fall_long", long_pulse, 2'b00);
        repeat (2) step(2'b00, 1'b0);

        // Rise coincident with a tick: that tick is not counted
        guard = 0;
        while (!tick_due() && guard < 20) begin
            step(2'b00, 1'b0);
            guard++;
        end
        if (guard >= 20) timeout("collide_rise_align");
        repeat (14) step(2'b01, 1'b0);

        // Reset while button 0 is in long-press, then release reset with it held
        guard = 0;
        while (!(held[0] && ticks[0] >= LT) && guard < 40) begin
            step(2'b01, 1'b0);
            guard++;
        end
        if (guard >= 40) timeout("reset_long_align");
        step(2'b01, 1'b1);
        chk("reset_mid_hold_blong", btn_long, 2'b00);
        chk("reset_mid_hold_release", release_pulse, 2'b00);
        step(2'b01, 1'b0);
        chk("post_reset_press", press_pulse, 2'b01);
        repeat (3) step(2'b01, 1'b0);
        repeat (2) step(2'b00, 1'b0);

        // Independence: simultaneous rise, then drop button 0 only
        step(2'b11, 1'b0);
        chk("both_press", press_pulse, 2'b11);
        repeat (2) step(2'b11, 1'b0);
        repeat (20) step(2'b10, 1'b0);
        repeat (2) step(2'b00, 1'b0);

        // Random activity: sticky levels so long presses and repeats occur
        rb = '0;
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, 9) == 0) rb[i] = ~rb[i];
            rr = ($urandom_range(0, 199) == 0);
            step(rb, rr);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
